// File: rtl/adc_responder_if.sv
// SPI bus between an ADC master and the responder; the slave modport is the ADC side.
interface adc_responder_if;
  logic ncs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output ncs, output mosi, input miso, input miso_oe);
  modport slave  (input ncs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/adc_responder.sv
// MCP3002-style 2-channel ADC responder: decodes the command on posedge sclk,
// shifts the latched result out on negedge sclk (null bit, MSB-first, optional LSB-first tail).
module adc_responder #(
  parameter int WIDTH     = 10,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 sclk,
  input  logic                 reset,
  adc_responder_if.slave       spi,
  input  logic [WIDTH-1:0]     sample0,
  input  logic [WIDTH-1:0]     sample1,
  output logic                 busy,
  output logic                 cmd_sgl,
  output logic                 cmd_odd,
  output logic                 cmd_msbf,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] frame_count
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_CMD,
    S_NULL,
    S_DATA,
    S_LSB,
    S_TAIL
  } state_t;

  state_t               state_q;
  logic [BW-1:0]        bit_q;
  logic [WIDTH-1:0]     data_q;
  logic                 busy_q;
  logic                 sgl_q;
  logic                 odd_q;
  logic                 msbf_q;
  logic                 frame_done_q;
  logic [CNT_WIDTH-1:0] frame_count_q;
  logic                 miso_q;
  logic                 drive_en_q;

  logic [WIDTH:0]       diff01_d;
  logic [WIDTH:0]       diff10_d;
  logic [WIDTH-1:0]     result_d;

  // Differential modes subtract at WIDTH+1 bits so a borrow clamps to zero instead of wrapping.
  always_comb begin
    diff01_d = {1'b0, sample0} - {1'b0, sample1};
    diff10_d = {1'b0, sample1} - {1'b0, sample0};
    result_d = sample0;
    case ({sgl_q, odd_q})
      2'b10:   result_d = sample0;
      2'b11:   result_d = sample1;
      2'b00:   result_d = diff01_d[WIDTH] ? '0 : diff01_d[WIDTH-1:0];
      default: result_d = diff10_d[WIDTH] ? '0 : diff10_d[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bit_q         <= '0;
      data_q        <= '0;
      busy_q        <= 1'b0;
      sgl_q         <= 1'b0;
      odd_q         <= 1'b0;
      msbf_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (spi.ncs) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_WAIT_START;
          S_WAIT_START: begin
            if (spi.mosi) begin
              state_q <= S_CMD;
              busy_q  <= 1'b1;
              bit_q   <= '0;
            end
          end
          S_CMD: begin
            bit_q <= bit_q + 1'b1;
            if (bit_q == BW'(0)) begin
              sgl_q <= spi.mosi;
            end else if (bit_q == BW'(1)) begin
              odd_q <= spi.mosi;
            end else begin
              msbf_q  <= spi.mosi;
              data_q  <= result_d;
              state_q <= S_NULL;
            end
          end
          S_NULL: begin
            state_q <= S_DATA;
            bit_q   <= LAST;
          end
          S_DATA: begin
            if (bit_q == '0) begin
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 1'b1;
              state_q       <= msbf_q ? S_TAIL : S_LSB;
              bit_q         <= BW'(1);
            end else begin
              bit_q <= bit_q - 1'b1;
            end
          end
          S_LSB: begin
            if (bit_q == LAST) begin
              state_q <= S_TAIL;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
          S_TAIL: state_q <= S_TAIL;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Launch side: follows the state settled by the preceding rising edge.
  always_ff @(negedge sclk or posedge reset) begin
    if (reset) begin
      miso_q     <= 1'b0;
      drive_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_NULL, S_TAIL: begin
          miso_q     <= 1'b0;
          drive_en_q <= 1'b1;
        end
        S_DATA, S_LSB: begin
          miso_q     <= data_q[bit_q];
          drive_en_q <= 1'b1;
        end
        default: begin
          miso_q     <= 1'b0;
          drive_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = drive_en_q & ~spi.ncs;
  assign busy        = busy_q;
  assign cmd_sgl     = sgl_q;
  assign cmd_odd     = odd_q;
  assign cmd_msbf    = msbf_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: vector table of full frames plus abort, reset and wrap sequences.
module tb_adc_responder;
  localparam int W  = 10;
  localparam int CW = 8;

  logic          sclk = 1'b0;
  logic          reset;
  logic [W-1:0]  sample0;
  logic [W-1:0]  sample1;
  logic          busy;
  logic          cmd_sgl;
  logic          cmd_odd;
  logic          cmd_msbf;
  logic          frame_done;
  logic [CW-1:0] frame_count;

  adc_responder_if bus();

  adc_responder #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .sclk       (sclk),
    .reset      (reset),
    .spi        (bus),
    .sample0    (sample0),
    .sample1    (sample1),
    .busy       (busy),
    .cmd_sgl    (cmd_sgl),
    .cmd_odd    (cmd_odd),
    .cmd_msbf   (cmd_msbf),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    logic [W-1:0] post_s0;
    logic [W-1:0] post_s1;
    logic         sgl;
    logic         odd;
    logic         msbf;
    logic [W-1:0] exp;
  } vec_t;

  vec_t          vecs[8];
  int            n_chk  = 0;
  int            n_fail = 0;
  bit            quiet  = 0;
  logic [CW-1:0] exp_cnt;
  logic [W-1:0]  abort_word;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    if (!quiet) begin
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
    end
  endtask

  task automatic chk_v(input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (!quiet) begin
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
    end
  endtask

  // One rising edge with mosi set up beforehand; returns 1ns after the edge.
  task automatic step(input logic m);
    bus.mosi = m;
    @(posedge sclk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    bus.ncs = 1'b0;
    step(1'b0);
    chk_b({tag, " busy_pre"}, busy, 1'b0);
    step(1'b1);
    chk_b({tag, " busy_r0"}, busy, 1'b1);
    chk_b({tag, " oe_r0"}, bus.miso_oe, 1'b0);
    step(v.sgl);
    step(v.odd);
    step(v.msbf);
    sample0 = v.post_s0;
    sample1 = v.post_s1;
    chk_b({tag, " sgl"}, cmd_sgl, v.sgl);
    chk_b({tag, " odd"}, cmd_odd, v.odd);
    chk_b({tag, " msbf"}, cmd_msbf, v.msbf);
    chk_b({tag, " oe_r3"}, bus.miso_oe, 1'b0);
    step(1'($urandom));
    chk_b({tag, " null_bit"}, bus.miso, 1'b0);
    chk_b({tag, " oe_r4"}, bus.miso_oe, 1'b1);
    for (int k = 5; k <= 14; k++) begin
      step(1'($urandom));
      chk_b($sformatf("%s msb_r%0d", tag, k), bus.miso, v.exp[14-k]);
      chk_b($sformatf("%s done_r%0d", tag, k), frame_done, k == 14);
    end
    exp_cnt = exp_cnt + 1'b1;
    chk_v({tag, " count"}, 16'(frame_count), 16'(exp_cnt));
    if (v.msbf) begin
      for (int k = 15; k <= 17; k++) begin
        step(1'($urandom));
        chk_b($sformatf("%s tail_r%0d", tag, k), bus.miso, 1'b0);
        chk_b($sformatf("%s done_r%0d", tag, k), frame_done, 1'b0);
      end
    end else begin
      for (int k = 15; k <= 23; k++) begin
        step(1'($urandom));
        chk_b($sformatf("%s lsb_r%0d", tag, k), bus.miso, v.exp[k-14]);
        chk_b($sformatf("%s done_r%0d", tag, k), frame_done, 1'b0);
      end
      step(1'b1);
      chk_b({tag, " tail_r24"}, bus.miso, 1'b0);
    end
    chk_b({tag, " oe_tail"}, bus.miso_oe, 1'b1);
    chk_b({tag, " busy_tail"}, busy, 1'b1);
    bus.ncs = 1'b1;
    #1;
    chk_b({tag, " oe_release"}, bus.miso_oe, 1'b0);
    step(1'b0);
    chk_b({tag, " busy_end"}, busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{10'h2A5, 10'h000, 10'h2A5, 10'h000, 1'b1, 1'b0, 1'b1, 10'h2A5};
    vecs[1] = '{10'h000, 10'h3FF, 10'h000, 10'h000, 1'b1, 1'b1, 1'b1, 10'h3FF};
    vecs[2] = '{10'h100, 10'h180, 10'h100, 10'h180, 1'b0, 1'b0, 1'b1, 10'h000};
    vecs[3] = '{10'h100, 10'h180, 10'h100, 10'h180, 1'b0, 1'b1, 1'b1, 10'h080};
    vecs[4] = '{10'h2A5, 10'h000, 10'h2A5, 10'h000, 1'b1, 1'b0, 1'b0, 10'h2A5};
    vecs[5] = '{10'h3FF, 10'h001, 10'h3FF, 10'h001, 1'b0, 1'b0, 1'b0, 10'h3FE};
    vecs[6] = '{10'h3FF, 10'h000, 10'h3FF, 10'h000, 1'b0, 1'b1, 1'b1, 10'h000};
    vecs[7] = '{10'h155, 10'h2AA, 10'h155, 10'h000, 1'b1, 1'b1, 1'b0, 10'h2AA};

    reset    = 1'b1;
    bus.ncs  = 1'b1;
    bus.mosi = 1'b0;
    sample0  = '0;
    sample1  = '0;
    exp_cnt  = '0;
    #12;
    chk_b("rst miso", bus.miso, 1'b0);
    chk_b("rst oe", bus.miso_oe, 1'b0);
    chk_b("rst busy", busy, 1'b0);
    chk_b("rst sgl", cmd_sgl, 1'b0);
    chk_b("rst odd", cmd_odd, 1'b0);
    chk_b("rst msbf", cmd_msbf, 1'b0);
    chk_b("rst done", frame_done, 1'b0);
    chk_v("rst count", 16'(frame_count), 16'h0000);
    reset = 1'b0;
    step(1'b0);
    step(1'b0);

    for (int i = 0; i < 8; i++) begin
      sample0 = vecs[i].s0;
      sample1 = vecs[i].s1;
      run_frame(vecs[i], $sformatf("v%0d", i));
    end

    // Three leading zeros before the start bit, then abort after R8.
    abort_word = 10'h2A5;
    sample0 = abort_word;
    sample1 = 10'h000;
    bus.ncs = 1'b0;
    step(1'b0);
    repeat (3) step(1'b0);
    chk_b("ab busy_lead", busy, 1'b0);
    step(1'b1);
    chk_b("ab busy_r0", busy, 1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    chk_b("ab null_bit", bus.miso, 1'b0);
    for (int k = 5; k <= 8; k++) begin
      step(1'b0);
      chk_b($sformatf("ab msb_r%0d", k), bus.miso, abort_word[14-k]);
    end
    bus.ncs = 1'b1;
    #1;
    chk_b("ab oe_release", bus.miso_oe, 1'b0);
    step(1'b0);
    chk_b("ab busy", busy, 1'b0);
    for (int k = 10; k <= 17; k++) begin
      step(1'b1);
      chk_b($sformatf("ab done_r%0d", k), frame_done, 1'b0);
      chk_v($sformatf("ab count_r%0d", k), 16'(frame_count), 16'(exp_cnt));
    end
    chk_b("ab miso_idle", bus.miso, 1'b0);
    sample0 = vecs[0].s0;
    sample1 = vecs[0].s1;
    run_frame(vecs[0], "post_abort");

    // Reset in the middle of the data phase.
    sample0 = 10'h2A5;
    bus.ncs = 1'b0;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    for (int k = 4; k <= 10; k++) step(1'b0);
    chk_b("mr busy_r10", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk_b("mr miso", bus.miso, 1'b0);
    chk_b("mr oe", bus.miso_oe, 1'b0);
    chk_b("mr busy", busy, 1'b0);
    chk_b("mr sgl", cmd_sgl, 1'b0);
    chk_v("mr count", 16'(frame_count), 16'h0000);
    exp_cnt = '0;
    bus.ncs = 1'b1;
    step(1'b0);
    reset = 1'b0;
    step(1'b0);

    // Counter wrap: 255 quiet frames, then one checked frame.
    sample0 = vecs[0].s0;
    sample1 = vecs[0].s1;
    quiet = 1;
    for (int i = 0; i < 255; i++) run_frame(vecs[0], "fill");
    quiet = 0;
    chk_v("wrap pre", 16'(frame_count), 16'h00FF);
    sample0 = vecs[3].s0;
    sample1 = vecs[3].s1;
    run_frame(vecs[3], "wrap");
    chk_v("wrap post", 16'(frame_count), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
